mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port arbiter for a shared single-port RAM. It grants one
//                owner at a time, registers a read-valid pulse one cycle after
//                each granted read, and alternates owners when both request.
//                Optional macro ARB_BURST_LIMIT_EN hands the RAM to the
//                waiting port after MAX_BURST consecutive grants.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int SIZE      = 10,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [SIZE-1:0] m0_addr,
    input  logic [31:0]     m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [31:0]     m0_rdata,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [SIZE-1:0] m1_addr,
    input  logic [31:0]     m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [31:0]     m1_rdata,
    output logic            wrEn,
    output logic [SIZE-1:0] addr_toRAM,
    output logic [31:0]     data_toRAM,
    input  logic [31:0]     data_fromRAM
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] c_cnt_max = 4'hF;
`ifdef ARB_BURST_LIMIT_EN
    // Count value seen on the last grant a burst is allowed to take.
    localparam logic [3:0] c_burst_last = 4'(MAX_BURST - 1);
`endif

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_burst_cnt;
    logic [3:0] w_burst_cnt_nxt;
    logic [3:0] w_burst_inc;
    logic       r_last_owner;
    logic       w_last_owner_nxt;
    logic       r_m0_rvalid;
    logic       r_m1_rvalid;

    // Saturating increment of the burst counter.
    assign w_burst_inc = (r_burst_cnt == c_cnt_max) ? c_cnt_max : r_burst_cnt + 4'd1;

    // State, burst counter and last-owner registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_burst_cnt  <= 4'd0;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    // Next-state logic plus grant and RAM-bus outputs for the current owner.
    always_comb begin
        w_state_nxt      = r_state;
        w_burst_cnt_nxt  = r_burst_cnt;
        w_last_owner_nxt = r_last_owner;
        m0_gnt           = 1'b0;
        m1_gnt           = 1'b0;
        wrEn             = 1'b0;
        addr_toRAM       = '0;
        data_toRAM       = '0;
        case (r_state)
            ST_IDLE: begin
                // Tie goes to the port that did not own the RAM last.
                if (m0_req && m1_req) begin
                    w_burst_cnt_nxt  = 4'd0;
                    w_last_owner_nxt = ~r_last_owner;
                    w_state_nxt      = r_last_owner ? ST_OWN0 : ST_OWN1;
                end else if (m0_req) begin
                    w_burst_cnt_nxt  = 4'd0;
                    w_last_owner_nxt = 1'b0;
                    w_state_nxt      = ST_OWN0;
                end else if (m1_req) begin
                    w_burst_cnt_nxt  = 4'd0;
                    w_last_owner_nxt = 1'b1;
                    w_state_nxt      = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (m0_req) begin
                    m0_gnt          = 1'b1;
                    wrEn            = m0_we;
                    addr_toRAM      = m0_addr;
                    data_toRAM      = m0_wdata;
                    w_burst_cnt_nxt = w_burst_inc;
`ifdef ARB_BURST_LIMIT_EN
                    if ((r_burst_cnt == c_burst_last) && m1_req) begin
                        w_state_nxt      = ST_OWN1;
                        w_burst_cnt_nxt  = 4'd0;
                        w_last_owner_nxt = 1'b1;
                    end
`endif
                end else begin
                    // Owner released: hand over directly or fall back to idle.
                    w_burst_cnt_nxt = 4'd0;
                    if (m1_req) begin
                        w_state_nxt      = ST_OWN1;
                        w_last_owner_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_OWN1: begin
                if (m1_req) begin
                    m1_gnt          = 1'b1;
                    wrEn            = m1_we;
                    addr_toRAM      = m1_addr;
                    data_toRAM      = m1_wdata;
                    w_burst_cnt_nxt = w_burst_inc;
`ifdef ARB_BURST_LIMIT_EN
                    if ((r_burst_cnt == c_burst_last) && m0_req) begin
                        w_state_nxt      = ST_OWN0;
                        w_burst_cnt_nxt  = 4'd0;
                        w_last_owner_nxt = 1'b0;
                    end
`endif
                end else begin
                    w_burst_cnt_nxt = 4'd0;
                    if (m0_req) begin
                        w_state_nxt      = ST_OWN0;
                        w_last_owner_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read-valid pulse one cycle after a granted read; writes never return data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
        end else begin
            r_m0_rvalid <= m0_gnt & ~m0_we;
            r_m1_rvalid <= m1_gnt & ~m1_we;
        end
    end

    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;
    assign m0_rdata  = r_m0_rvalid ? data_fromRAM : 32'd0;
    assign m1_rdata  = r_m1_rvalid ? data_fromRAM : 32'd0;

endmodule
`default_nettype wire
